// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request bus between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC ownership, imem handshake, IF/ID load/clear control.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   stall_i,
   input  logic                   redirect_valid_i,
   input  logic [31:0]            redirect_pc_i,
   if_fetch_unit_if.master        imem_io,
   output logic                   ifid_wen_o,
   output logic                   ifid_clear_o,
   output logic [31:0]            ifid_pc_o,
   output logic [31:0]            ifid_is_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]            fetch_cnt_o,
   output logic [31:0]            bubble_cnt_o
`endif
);

   typedef enum logic [1:0] {StIdle, StReq, StHold, StDrop} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_is_q, buf_is_d;
   logic [31:0] redirect_tgt;
   logic        unused_rpc;

   assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
   assign unused_rpc   = ^redirect_pc_i[1:0];

   // DROP keeps the wrong-path address on the bus until its ready arrives.
   assign imem_io.req  = (state_q == StReq) || (state_q == StDrop);
   assign imem_io.addr = (state_q == StDrop) ? req_addr_q : pc_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      buf_pc_d     = buf_pc_q;
      buf_is_d     = buf_is_q;
      ifid_wen_o   = !stall_i;
      ifid_clear_o = 1'b1;
      ifid_pc_o    = 32'h0;
      ifid_is_o    = 32'h0;

      unique case (state_q)
         StIdle: state_d = StReq;
         StReq: begin
            req_addr_d = pc_q;
            if (imem_io.ready) begin
               ifid_pc_o    = pc_q;
               ifid_is_o    = imem_io.rdata;
               ifid_clear_o = 1'b0;
               if (!stall_i) begin
                  ifid_wen_o = 1'b1;
                  pc_d       = pc_q + 32'd4;
               end else begin
                  ifid_wen_o = 1'b0;
                  buf_pc_d   = pc_q;
                  buf_is_d   = imem_io.rdata;
                  state_d    = StHold;
               end
            end
         end
         StHold: begin
            ifid_pc_o    = buf_pc_q;
            ifid_is_o    = buf_is_q;
            ifid_clear_o = 1'b0;
            if (stall_i) begin
               ifid_wen_o = 1'b0;
            end else begin
               ifid_wen_o = 1'b1;
               pc_d       = buf_pc_q + 32'd4;
               state_d    = StReq;
            end
         end
         StDrop: begin
            if (imem_io.ready) state_d = StReq;
         end
         default: state_d = StIdle;
      endcase

      // Redirect flushes IF/ID even under stall; an unfinished request must still drain.
      if (redirect_valid_i) begin
         ifid_wen_o   = 1'b1;
         ifid_clear_o = 1'b1;
         ifid_pc_o    = 32'h0;
         ifid_is_o    = 32'h0;
         pc_d         = redirect_tgt;
         state_d      = (((state_q == StReq) || (state_q == StDrop)) && !imem_io.ready) ?
                        StDrop : StReq;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         buf_pc_q   <= 32'h0;
         buf_is_q   <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         buf_pc_q   <= buf_pc_d;
         buf_is_q   <= buf_is_d;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, bubble_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_cnt_q  <= 32'h0;
         bubble_cnt_q <= 32'h0;
      end else if (ifid_wen_o) begin
         if (ifid_clear_o) bubble_cnt_q <= bubble_cnt_q + 32'd1;
         else              fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      end
   end

   assign fetch_cnt_o  = fetch_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage: owns the program counter, issues requests to instruction memory over a req/ready handshake, and produces the PC/instruction pair plus the write-enable and clear controls that load the IF/ID pipeline register. Redirects are accepted from EX (branch/jump resolution) and stalls from the hazard unit. Wrong-path and not-yet-arrived instructions are turned into cleared (all-zero) bubbles.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- stall  in  1  hazard unit holds IF/ID contents
- redirect_valid  in  1  EX requests fetch from redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 00)
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word-aligned
- imem_ready  in  1  imem_rdata valid this cycle; completes the request
- imem_rdata  in  32  fetched instruction
- ifid_wen  out  1  IF/ID register write enable
- ifid_clear  out  1  IF/ID register clear (bubble)
- ifid_pc  out  32  PC presented to IF/ID
- ifid_is  out  32  instruction presented to IF/ID
- fetch_cnt  out  32  only with IF_PERF_CNT_EN
- bubble_cnt  out  32  only with IF_PERF_CNT_EN

## Operation
- Registers: pc_q (next address to fetch), req_addr (address of outstanding request), buf_pc/buf_is (held instruction), state.
- States: IDLE, REQ, HOLD, DROP.
- IDLE: entered by reset only; imem_req=0; bubble output; next cycle -> REQ. Redirect here loads pc_q.
- REQ: imem_req=1, imem_addr=pc_q (req_addr<=pc_q on issue). Handshake completes in any cycle with imem_ready=1 (zero-wait allowed).
  - ready & !stall: ifid_wen=1, ifid_clear=0, ifid_pc=pc_q, ifid_is=imem_rdata; pc_q<=pc_q+4; stay REQ.
  - ready & stall: buf<=(pc_q, imem_rdata); ifid_wen=0; -> HOLD.
  - !ready: bubble (ifid_wen=!stall, ifid_clear=1); stay REQ, address held stable.
- HOLD: imem_req=0; ifid_pc/is = buf. While stall: ifid_wen=0. When !stall: ifid_wen=1, clear=0, pc_q<=buf_pc+4, -> REQ.
- DROP: outstanding request whose data is wrong-path. imem_req=1, imem_addr=req_addr (stable until ready). Bubble output. On ready: data discarded, -> REQ.
- Redirect (highest priority, overrides stall): that cycle ifid_wen=1, ifid_clear=1; pc_q<={redirect_pc[31:2],2'b00}.
  - REQ & ready: data discarded, stay REQ. REQ & !ready: -> DROP. HOLD: buf discarded, -> REQ. DROP: target updated, stay DROP. IDLE: -> REQ.
- Bubble = ifid_wen=1 & ifid_clear=1 when !stall; never ifid_clear=0 for a discarded or held-invalid instruction.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0000_0000.

## Timing
- Reset values: state=IDLE, pc_q=RESET_PC, imem_req=0, imem_addr=RESET_PC, ifid_wen=1, ifid_clear=1, ifid_pc=0, ifid_is=0, counters=0.
- First request at RESET_PC in the 2nd cycle after rstn deasserts (1 IDLE cycle).
- Zero-wait memory: one instruction per cycle; instruction is at IF/ID inputs in the same cycle as imem_ready, registered at that cycle's end.
- Redirect at cycle N: imem_addr=redirect_pc at N+1 (unless in DROP: after the pending ready, +1 cycle).
- Stall release from HOLD at cycle N: held instruction written at N; next request issued at N+1.
- Outputs ifid_* are combinational from state, buf and imem_rdata; imem_req/imem_addr depend only on registered state.
- Reset asserted mid-request: request dropped immediately, any late imem_ready ignored.

## Configuration
- IF_PERF_CNT_EN defined: fetch_cnt increments on ifid_wen & !ifid_clear; bubble_cnt increments on ifid_wen & ifid_clear; both wrap at 2^32, reset to 0.
- Not defined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset, imem_ready=1, rdata=addr^32'hA5A5_0000: after IDLE, ifid_pc 0,4,8,... on consecutive cycles, ifid_clear=0, is matches.
- imem_ready low 2 cycles at addr 0x8: two bubbles (wen=1, clear=1), imem_addr stays 0x8, then pc 0x8 written.
- stall high 3 cycles while ready at 0x8: HOLD, imem_req=0, wen=0; release -> pc 0x8 written, next imem_addr 0xC.
- redirect_pc=0x103 while 0x10 pending: DROP, 0x10 data never written with clear=0, next request 0x100.
- redirect and stall same cycle: ifid_wen=1, ifid_clear=1, next imem_addr = redirect target.
- redirect to 0xFFFF_FFFC, zero-wait: next address 0x0000_0000; with IF_PERF_CNT_EN, fetch_cnt/bubble_cnt match observed writes.
